// File: rtl/s3ga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// s3ga_cfg_pkg
//
// Definitions shared by the S3GA configuration-chain blocks:
//   - opcode values recognised on the config chain while idle
//   - encoding of the frame-loader state machine
//   - constant functions giving the frame geometry for a context memory
//
// No ports (package).
// ---------------------------------------------------------------------------
package s3ga_cfg_pkg;

    // Opcodes accepted on cfg_i while the loader is idle.
    localparam int OP_WR = 1;   // load a new frame into the contexts
    localparam int OP_RD = 2;   // stream the stored frame back out on cfg_o

    // Frame-loader states.
    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,   // idle, sampling opcodes
        ST_CFG  = 3'd1,   // receiving data segments
        ST_PAR  = 3'd2,   // receiving the parity segment
        ST_RDBK = 3'd3,   // emitting stored segments, then their parity
        ST_PASS = 3'd4    // passing the chain through until re-armed
    } cfg_st_t;

    // Number of CFG_W-wide segments needed to hold one w-bit context.
    function automatic int segs(input int w, input int cfg_w);
        return (w + cfg_w - 1) / cfg_w;
    endfunction

    // Number of data segments in a full frame of m contexts.
    function automatic int frame(input int m, input int w, input int cfg_w);
        return m * segs(w, cfg_w);
    endfunction

endpackage

// File: rtl/cfg_frame_fsm.sv
// ---------------------------------------------------------------------------
// cfg_frame_fsm
//
// Frame sequencer for the context configuration memory. Tracks which phase
// of a frame the chain is in, counts data segments and accumulates the
// running XOR parity of the segments that pass through.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   arm       in   synchronous re-arm; forces WAIT from any state
//   rd_allow  in   readback permitted (a good frame is resident)
//   cfg_i     in   config chain input (opcodes, data, parity)
//   par_src   in   segment value folded into the parity accumulator
//   st        out  current state
//   seg       out  segment index within the frame
//   par       out  parity accumulated so far
//   par_ok    out  cfg_i equals the accumulated parity
// ---------------------------------------------------------------------------
module cfg_frame_fsm
    import s3ga_cfg_pkg::*;
#(
    parameter  int M     = 8,
    parameter  int W     = 8,
    parameter  int CFG_W = 4,
    localparam int FRAME = frame(M, W, CFG_W),
    localparam int SEG_W = $clog2(FRAME + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             rd_allow,
    input  logic [CFG_W-1:0] cfg_i,
    input  logic [CFG_W-1:0] par_src,
    output cfg_st_t          st,
    output logic [SEG_W-1:0] seg,
    output logic [CFG_W-1:0] par,
    output logic             par_ok
);

    // Only meaningful in ST_PAR, where cfg_i carries the expected parity.
    assign par_ok = (cfg_i == par);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= ST_WAIT;
            seg <= '0;
            par <= '0;
        end else if (arm) begin
            // Re-arm beats any opcode or data presented in the same cycle.
            st  <= ST_WAIT;
            seg <= '0;
            par <= '0;
        end else begin
            case (st)
                ST_WAIT: begin
                    seg <= '0;
                    par <= '0;
                    if (cfg_i == CFG_W'(OP_WR)) begin
                        st <= ST_CFG;
                    end else if ((cfg_i == CFG_W'(OP_RD)) && rd_allow) begin
                        st <= ST_RDBK;
                    end
                end

                ST_CFG: begin
                    // Pad bits of the last segment still count toward parity.
                    par <= par ^ par_src;
                    if (seg == SEG_W'(FRAME - 1)) begin
                        seg <= '0;
                        st  <= ST_PAR;
                    end else begin
                        seg <= seg + 1'b1;
                    end
                end

                ST_PAR: begin
                    par <= '0;
                    st  <= ST_PASS;
                end

                ST_RDBK: begin
                    // seg runs one past the last data segment; that extra
                    // cycle is where the accumulated parity is emitted.
                    if (seg == SEG_W'(FRAME)) begin
                        seg <= '0;
                        par <= '0;
                        st  <= ST_PASS;
                    end else begin
                        par <= par ^ par_src;
                        seg <= seg + 1'b1;
                    end
                end

                ST_PASS: begin
                    seg <= '0;
                end

                default: begin
                    st  <= ST_WAIT;
                    seg <= '0;
                    par <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cfg_ctx_ram.sv
// ---------------------------------------------------------------------------
// cfg_ctx_ram
//
// M-context configuration memory on the S3GA config chain. A frame of
// M*SEGS segments loads every context (segment k targets context k mod M,
// field k / M), followed by a parity segment that decides whether the load
// is accepted. A resident good frame can be streamed back out on cfg_o
// without disturbing it. After a frame the block passes the chain through
// until re-armed. The current context rotates every cycle and is presented
// on o while a good frame is resident.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   arm      in   synchronous re-arm pulse; returns the loader to WAIT
//   cfg_i    in   config chain input
//   cfg_o    out  config chain output (registered)
//   o        out  data of the current context, zero unless cfg_ok
//   ctx      out  index of the current context
//   cfg_ok   out  last frame loaded with good parity
//   cfg_err  out  last frame failed parity
// ---------------------------------------------------------------------------
module cfg_ctx_ram
    import s3ga_cfg_pkg::*;
#(
    parameter  int M     = 8,
    parameter  int W     = 8,
    parameter  int CFG_W = 4,
    localparam int CTX_W = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [CFG_W-1:0] cfg_i,
    output logic [CFG_W-1:0] cfg_o,
    output logic [W-1:0]     o,
    output logic [CTX_W-1:0] ctx,
    output logic             cfg_ok,
    output logic             cfg_err
);

    localparam int SEGS  = segs(W, CFG_W);
    localparam int FRAME = frame(M, W, CFG_W);
    localparam int SEG_W = $clog2(FRAME + 1);
    // Context width rounded up to whole segments; the pad bits above W
    // exist only transiently in the shift expressions below.
    localparam int PADW  = SEGS * CFG_W;

    logic [W-1:0]     mem [M];

    cfg_st_t          st;
    logic [SEG_W-1:0] seg;
    logic [CFG_W-1:0] par;
    logic             par_ok;
    logic [CFG_W-1:0] par_src;

    int               seg_i;
    int               row;
    logic [CTX_W-1:0] col;
    logic [W-1:0]     wr_word;
    logic [CFG_W-1:0] rd_field;

    cfg_frame_fsm #(
        .M     (M),
        .W     (W),
        .CFG_W (CFG_W)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .rd_allow (cfg_ok),
        .cfg_i    (cfg_i),
        .par_src  (par_src),
        .st       (st),
        .seg      (seg),
        .par      (par),
        .par_ok   (par_ok)
    );

    // Segment addressing: contexts are interleaved, so consecutive segments
    // walk across contexts first and move to the next field every M segments.
    // In the readback parity cycle seg equals FRAME, which lands past the
    // last field and yields a zero rd_field; that value is never used.
    always_comb begin
        seg_i    = int'(seg);
        col      = CTX_W'(seg_i % M);
        row      = seg_i / M;
        // Merge cfg_i into its field; bits shifted above W are the pad bits
        // and fall away in the truncation.
        wr_word  = (mem[col] & ~W'(PADW'({CFG_W{1'b1}}) << (row * CFG_W)))
                 | W'(PADW'(cfg_i) << (row * CFG_W));
        // Zero-extension to PADW supplies zero pad bits on the top field.
        rd_field = CFG_W'(PADW'(mem[col]) >> (row * CFG_W));
        par_src  = (st == ST_RDBK) ? rd_field : cfg_i;
    end

    // Free-running context rotation, independent of the loader.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctx <= '0;
        end else if (ctx == CTX_W'(M - 1)) begin
            ctx <= '0;
        end else begin
            ctx <= ctx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < M; c++) mem[c] <= '0;
            cfg_o   <= '0;
            cfg_ok  <= 1'b0;
            cfg_err <= 1'b0;
        end else if (arm) begin
            cfg_o <= '0;
            // Re-arming during a load abandons it: the partially written
            // contexts must never be presented as valid.
            if (st == ST_CFG || st == ST_PAR) begin
                for (int c = 0; c < M; c++) mem[c] <= '0;
                cfg_ok  <= 1'b0;
                cfg_err <= 1'b0;
            end
        end else begin
            cfg_o <= '0;
            case (st)
                ST_CFG: begin
                    mem[col] <= wr_word;
                end

                ST_PAR: begin
                    if (par_ok) begin
                        cfg_ok  <= 1'b1;
                        cfg_err <= 1'b0;
                    end else begin
                        for (int c = 0; c < M; c++) mem[c] <= '0;
                        cfg_ok  <= 1'b0;
                        cfg_err <= 1'b1;
                    end
                end

                ST_RDBK: begin
                    cfg_o <= (seg == SEG_W'(FRAME)) ? par : rd_field;
                end

                ST_PASS: begin
                    cfg_o <= cfg_i;
                end

                default: begin
                end
            endcase
        end
    end

    assign o = cfg_ok ? mem[ctx] : '0;

endmodule

// File: tb/tb_cfg_ctx_ram.sv
module tb_cfg_ctx_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm;
    logic [3:0] cfg_i;
    logic [3:0] cfg_o;
    logic [5:0] o;
    logic [1:0] ctx;
    logic       cfg_ok;
    logic       cfg_err;

    int total = 0;
    int bad   = 0;
    int tb_ctx = 0;

    logic [3:0] d1 [8];
    logic [3:0] d2 [8];
    logic [3:0] cur [8];
    logic [5:0] exp1 [4];
    logic [5:0] exp2 [4];
    logic [5:0] expo [4];

    cfg_ctx_ram #(.M(4), .W(6), .CFG_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .cfg_i   (cfg_i),
        .cfg_o   (cfg_o),
        .o       (o),
        .ctx     (ctx),
        .cfg_ok  (cfg_ok),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the bench's own context counter follows rst at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) tb_ctx = (tb_ctx + 1) % 4;
        #1;
    endtask

    // Opcode 1, eight data segments from cur, then parity p.
    task automatic send_frame(input logic [3:0] p, input logic ok_before);
        cfg_i = 4'd1;
        tick();
        for (int k = 0; k < 8; k++) begin
            cfg_i = cur[k];
            tick();
            chk("cfg_o_during_cfg", 32'(cfg_o), 32'd0);
        end
        chk("cfg_ok_before_parity", 32'(cfg_ok), 32'(ok_before));
        cfg_i = p;
        tick();
        cfg_i = 4'd0;
    endtask

    task automatic chk_ctx_o();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ctx_track", 32'(ctx), 32'(tb_ctx));
            chk("o_ctx_data", 32'(o), 32'(expo[tb_ctx]));
        end
    endtask

    initial begin
        d1   = '{4'h5, 4'hA, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
        d2   = '{4'h3, 4'hC, 4'h9, 4'h6, 4'h2, 4'h1, 4'h0, 4'h1};
        exp1 = '{6'h15, 6'h2A, 6'h3F, 6'h00};
        exp2 = '{6'h23, 6'h1C, 6'h09, 6'h16};

        // Reset, then idle rotation
        rst = 1'b0; arm = 1'b0; cfg_i = 4'd0; tb_ctx = 0;
        tick();
        tick();
        chk("rst_o", 32'(o), 32'd0);
        chk("rst_cfg_o", 32'(cfg_o), 32'd0);
        chk("rst_cfg_ok", 32'(cfg_ok), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_ctx", 32'(ctx), 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("idle_ctx", 32'(ctx), 32'(i % 4));
            chk("idle_o", 32'(o), 32'd0);
            chk("idle_cfg_o", 32'(cfg_o), 32'd0);
        end

        // Bad-parity frame
        cur = d1;
        send_frame(4'd1, 1'b0);
        chk("bad_cfg_err", 32'(cfg_err), 32'd1);
        chk("bad_cfg_ok", 32'(cfg_ok), 32'd0);
        chk("bad_o", 32'(o), 32'd0);
        expo = '{6'h00, 6'h00, 6'h00, 6'h00};
        chk_ctx_o();
        cfg_i = 4'hB;
        tick();
        chk("pass_after_bad", 32'(cfg_o), 32'hB);
        cfg_i = 4'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_pass_keeps_err", 32'(cfg_err), 32'd1);
        chk("arm_pass_ok", 32'(cfg_ok), 32'd0);
        chk("arm_cfg_o", 32'(cfg_o), 32'd0);

        // Good frame
        send_frame(4'd0, 1'b0);
        chk("good_cfg_ok", 32'(cfg_ok), 32'd1);
        chk("good_cfg_err", 32'(cfg_err), 32'd0);
        expo = exp1;
        chk_ctx_o();

        // Re-arm with a write opcode in the same cycle, then readback
        arm = 1'b1; cfg_i = 4'd1;
        tick();
        arm = 1'b0; cfg_i = 4'd0;
        chk("arm_keeps_ok", 32'(cfg_ok), 32'd1);
        chk("arm_clears_cfg_o", 32'(cfg_o), 32'd0);
        tick();
        cfg_i = 4'd2;
        tick();
        cfg_i = 4'd7;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rdbk_seg", 32'(cfg_o), 32'(d1[k]));
            chk("rdbk_o", 32'(o), 32'(expo[tb_ctx]));
        end
        tick();
        chk("rdbk_par", 32'(cfg_o), 32'd0);
        chk("rdbk_ok", 32'(cfg_ok), 32'd1);
        cfg_i = 4'd9;
        tick();
        chk("rdbk_pass_9", 32'(cfg_o), 32'd9);
        cfg_i = 4'd6;
        tick();
        chk("rdbk_pass_6", 32'(cfg_o), 32'd6);
        chk("rdbk_pass_o", 32'(o), 32'(expo[tb_ctx]));

        // Abort a write after segment 4, then load a fresh frame
        cfg_i = 4'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_i = 4'd1;
        tick();
        for (int k = 0; k < 5; k++) begin
            cfg_i = d1[k];
            tick();
        end
        chk("partial_ok_still", 32'(cfg_ok), 32'd1);
        chk("partial_o", 32'(o), 32'(expo[tb_ctx]));
        arm = 1'b1; cfg_i = d1[5];
        tick();
        arm = 1'b0; cfg_i = 4'd0;
        chk("abort_ok", 32'(cfg_ok), 32'd0);
        chk("abort_err", 32'(cfg_err), 32'd0);
        chk("abort_o", 32'(o), 32'd0);
        cur = d2;
        send_frame(4'd2, 1'b0);
        chk("fresh_ok", 32'(cfg_ok), 32'd1);
        chk("fresh_err", 32'(cfg_err), 32'd0);
        expo = exp2;
        chk_ctx_o();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_i = 4'd2;
        tick();
        cfg_i = 4'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rdbk2_seg", 32'(cfg_o), 32'(d2[k]));
        end
        tick();
        chk("rdbk2_par", 32'(cfg_o), 32'd2);

        // Asynchronous reset mid-readback
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_i = 4'd2;
        tick();
        cfg_i = 4'd0;
        tick();
        chk("rdbk3_seg0", 32'(cfg_o), 32'h3);
        tick();
        chk("rdbk3_seg1", 32'(cfg_o), 32'hC);
        #2;
        rst = 1'b0;
        #1;
        tb_ctx = 0;
        chk("arst_o", 32'(o), 32'd0);
        chk("arst_cfg_o", 32'(cfg_o), 32'd0);
        chk("arst_cfg_ok", 32'(cfg_ok), 32'd0);
        chk("arst_cfg_err", 32'(cfg_err), 32'd0);
        chk("arst_ctx", 32'(ctx), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        cfg_i = 4'd2;
        tick();
        cfg_i = 4'd5;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("rd_before_write_cfg_o", 32'(cfg_o), 32'd0);
        end
        chk("rd_before_write_ok", 32'(cfg_ok), 32'd0);
        chk("post_rst_ctx", 32'(ctx), 32'(tb_ctx));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
